gemm_result_reader: RTL

Drains the GEMM output memory C back out of the accelerator subsystem. It reads packed 2048-bit C words (64 × 32-bit signed results) from the single-port C SRAM after `done_o` of the accelerator. It unpacks each word and streams the elements one per beat on a valid/ready interface, in row-major order. It sits between the C SRAM read port and the host/result sink and is the read-side counterpart of the accelerator's C write path.

---
 rtl/gemm_pkg.sv | 20 ++
 rtl/gemm_word_unpacker.sv | 66 ++++++
 rtl/gemm_result_reader.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM result-reader slice.
//   - reader_state_e : drain FSM state encoding
//   - DefElemWidth / DefElemsPerWord : default element and packing geometry
//   - c_word_t : one packed C SRAM word at the default geometry
package gemm_pkg;

    localparam int unsigned DefElemWidth    = 32;
    localparam int unsigned DefElemsPerWord = 64;

    typedef logic [DefElemWidth*DefElemsPerWord-1:0] c_word_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_STREAM  = 3'd3,
        ST_DONE    = 3'd4
    } reader_state_e;

endpackage

// File: rtl/gemm_word_unpacker.sv
// Word buffer for the C result reader plus the lane-select mux.
// Optional feature macro: GEMM_RESULT_READER_PREFETCH_EN adds a staging
// buffer that captures the prefetched word and is swapped in on demand.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   i_load        : capture i_rdata into the active buffer
//   i_stage       : capture i_rdata into the staging buffer (prefetch only)
//   i_swap        : move the staged word into the active buffer (prefetch only)
//   i_rdata       : packed C word from SRAM
//   i_ptr         : lane select
//   o_elem        : selected element of the active buffer
module gemm_word_unpacker
    import gemm_pkg::*;
#(
    parameter int unsigned ElemWidth    = DefElemWidth,
    parameter int unsigned ElemsPerWord = DefElemsPerWord,
    parameter int unsigned PtrWidth     = $clog2(ElemsPerWord)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              i_load,
`ifdef GEMM_RESULT_READER_PREFETCH_EN
    input  logic                              i_stage,
    input  logic                              i_swap,
`endif
    input  logic [ElemWidth*ElemsPerWord-1:0] i_rdata,
    input  logic [PtrWidth-1:0]               i_ptr,
    output logic [ElemWidth-1:0]              o_elem
);

    logic [ElemsPerWord-1:0][ElemWidth-1:0] r_word;

`ifdef GEMM_RESULT_READER_PREFETCH_EN
    logic [ElemsPerWord-1:0][ElemWidth-1:0] r_stage;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stage <= '0;
        end else if (i_stage) begin
            r_stage <= i_rdata;
        end
    end

    // A swap in the same cycle the prefetched data lands must bypass the stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_word <= '0;
        end else if (i_load || (i_swap && i_stage)) begin
            r_word <= i_rdata;
        end else if (i_swap) begin
            r_word <= r_stage;
        end
    end
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_word <= '0;
        end else if (i_load) begin
            r_word <= i_rdata;
        end
    end
`endif

    assign o_elem = r_word[i_ptr];

endmodule

// File: rtl/gemm_result_reader.sv
// Drains packed C words from the single-port C SRAM and streams the 32-bit
// results one per beat, row-major, on a valid/ready interface.
// Optional feature macro: GEMM_RESULT_READER_PREFETCH_EN issues the next
// word read while the current word is still streaming, removing the
// two-cycle inter-word bubble.
// Ports:
//   clk_i, rst_ni           : clock, async active-low reset
//   start_i                 : start a drain (IDLE only)
//   base_addr_i/num_elems_i : first word address / element count
//   sram_c_addr_o/req_o     : C SRAM read address / port ownership
//   sram_c_rdata_i          : read data, one cycle after the address
//   elem_data_o/idx_o       : current element and its linear index
//   elem_valid_o/ready_i    : stream handshake
//   busy_o / done_o         : not idle / one-cycle completion pulse
module gemm_result_reader
    import gemm_pkg::*;
#(
    parameter int unsigned ElemWidth     = DefElemWidth,
    parameter int unsigned ElemsPerWord  = DefElemsPerWord,
    parameter int unsigned AddrWidth     = 12,
    parameter int unsigned SizeAddrWidth = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              start_i,
    input  logic [AddrWidth-1:0]              base_addr_i,
    input  logic [SizeAddrWidth-1:0]          num_elems_i,
    output logic [AddrWidth-1:0]              sram_c_addr_o,
    output logic                              sram_c_req_o,
    input  logic [ElemWidth*ElemsPerWord-1:0] sram_c_rdata_i,
    output logic [ElemWidth-1:0]              elem_data_o,
    output logic [SizeAddrWidth-1:0]          elem_idx_o,
    output logic                              elem_valid_o,
    input  logic                              elem_ready_i,
    output logic                              busy_o,
    output logic                              done_o
);

    localparam int unsigned PtrWidth = $clog2(ElemsPerWord);
    localparam logic [PtrWidth-1:0]      LastPtr = PtrWidth'(ElemsPerWord - 1);
    localparam logic [PtrWidth-1:0]      PtrOne  = PtrWidth'(1);
    localparam logic [SizeAddrWidth-1:0] CntOne  = SizeAddrWidth'(1);

    reader_state_e              r_state;
    logic [AddrWidth-1:0]       r_base;
    logic [SizeAddrWidth-1:0]   r_num;
    logic [SizeAddrWidth-1:0]   r_words;
    logic [SizeAddrWidth-1:0]   r_word_cnt;
    logic [SizeAddrWidth-1:0]   r_idx;
    logic [PtrWidth-1:0]        r_ptr;

    logic                       w_xfer;
    logic                       w_last_elem;
    logic                       w_last_lane;
    logic [SizeAddrWidth-1:0]   w_words_in;
    logic [AddrWidth-1:0]       w_fetch_addr;
    logic [ElemWidth-1:0]       w_elem;

    assign w_xfer       = (r_state == ST_STREAM) && elem_ready_i;
    assign w_last_elem  = (r_idx == r_num - CntOne);
    assign w_last_lane  = (r_ptr == LastPtr);
    // ceil(num / ElemsPerWord) without overflow; ElemsPerWord is a power of two.
    assign w_words_in   = (num_elems_i >> PtrWidth)
                        + SizeAddrWidth'(|num_elems_i[PtrWidth-1:0]);
    // Truncation gives the modulo-2^AddrWidth wrap.
    assign w_fetch_addr = r_base + AddrWidth'(r_word_cnt);

`ifdef GEMM_RESULT_READER_PREFETCH_EN
    logic r_pf_pending;
    logic w_pf_issue;
    logic w_swap;

    // Only words before the last one are streamed in full, so the lane
    // before the end is always reached when another word follows.
    assign w_pf_issue = w_xfer && (r_ptr == LastPtr - PtrOne)
                     && (r_word_cnt != r_words - CntOne);
    assign w_swap     = w_xfer && w_last_lane && !w_last_elem;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pf_pending <= 1'b0;
        end else begin
            r_pf_pending <= w_pf_issue;
        end
    end
`endif

    always_comb begin
        sram_c_req_o  = 1'b0;
        sram_c_addr_o = '0;
        if (r_state == ST_FETCH) begin
            sram_c_req_o  = 1'b1;
            sram_c_addr_o = w_fetch_addr;
        end
`ifdef GEMM_RESULT_READER_PREFETCH_EN
        else if (w_pf_issue) begin
            sram_c_req_o  = 1'b1;
            sram_c_addr_o = w_fetch_addr + AddrWidth'(1);
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_base     <= '0;
            r_num      <= '0;
            r_words    <= '0;
            r_word_cnt <= '0;
            r_idx      <= '0;
            r_ptr      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_idx <= '0;
                        if (num_elems_i == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_base     <= base_addr_i;
                            r_num      <= num_elems_i;
                            r_words    <= w_words_in;
                            r_word_cnt <= '0;
                            r_state    <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH:   r_state <= ST_CAPTURE;
                ST_CAPTURE: begin
                    r_ptr   <= '0;
                    r_state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (w_xfer) begin
                        r_idx <= r_idx + CntOne;
                        if (w_last_elem) begin
                            r_state <= ST_DONE;
                        end else if (w_last_lane) begin
                            r_word_cnt <= r_word_cnt + CntOne;
                            r_ptr      <= '0;
`ifndef GEMM_RESULT_READER_PREFETCH_EN
                            r_state    <= ST_FETCH;
`endif
                        end else begin
                            r_ptr <= r_ptr + PtrOne;
                        end
                    end
                end
                ST_DONE:    r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    gemm_word_unpacker #(
        .ElemWidth    (ElemWidth),
        .ElemsPerWord (ElemsPerWord),
        .PtrWidth     (PtrWidth)
    ) u_unpacker (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_load  (r_state == ST_CAPTURE),
`ifdef GEMM_RESULT_READER_PREFETCH_EN
        .i_stage (r_pf_pending),
        .i_swap  (w_swap),
`endif
        .i_rdata (sram_c_rdata_i),
        .i_ptr   (r_ptr),
        .o_elem  (w_elem)
    );

    assign elem_valid_o = (r_state == ST_STREAM);
    assign elem_data_o  = elem_valid_o ? w_elem : '0;
    assign elem_idx_o   = r_idx;
    assign busy_o       = (r_state != ST_IDLE);
    assign done_o       = (r_state == ST_DONE);

endmodule
